// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of mem_port_arbiter: at most one access in flight.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: the master raises mem_req with we/addr/wdata/be already stable and
    // holds all of them until the slave answers with mem_ready = 1 (one cycle, read data
    // valid in that same cycle). mem_ready while mem_req = 0 carries no meaning.
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the core's fetch and data ports:
// grant FSM, per-access timeout, data-port byte enables and pipeline stall.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 64,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [AW-1:0]      if_addr,
    output logic               if_ack,
    output logic [DW-1:0]      if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [AW-1:0]      d_addr,
    input  logic [DW-1:0]      d_wdata,
    input  logic [2:0]         d_funct3,
    output logic               d_ack,
    output logic [DW-1:0]      d_rdata,
    output logic               err,
    mem_port_arbiter_if.master mem,
    output logic               core_stall,
    output logic [1:0]         dbgState
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

    logic [1:0]    state;
    logic [TW-1:0] toCnt;
    logic [RW-1:0] runCnt;

    logic [3:0]    dBe;
    logic [DW-1:0] dWdata;
    logic          dMisalign;

    logic inIdle;
    logic toHit;
    logic doneI;
    logic doneD;
    logic decide;
    logic candI;
    logic candD;
    logic pickD;
    logic pickI;
    logic grantI;
    logic grantD;
    logic misD;

    // Fetches are always word accesses; the low address bits carry no information.
    logic unusedIfAddrBits;
    assign unusedIfAddrBits = ^if_addr[1:0];

    // Data-port lane decode. Loads keep all four enables; the core extends the raw word.
    always_comb begin
        dBe       = 4'b1111;
        dWdata    = d_wdata;
        dMisalign = 1'b0;
        case (d_funct3)
            3'b000, 3'b100: begin
                if (d_we) dBe = 4'b0001 << d_addr[1:0];
                dWdata = {4{d_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                dMisalign = d_addr[0];
                if (d_we) dBe = 4'b0011 << {d_addr[1], 1'b0};
                dWdata = {2{d_wdata[15:0]}};
            end
            3'b010: begin
                dMisalign = (d_addr[1:0] != 2'b00);
            end
            default: begin
                dMisalign = 1'b1;
            end
        endcase
    end

    // A timeout only fires when the memory has not answered on the last allowed cycle.
    assign inIdle = (state == IDLE);
    assign toHit  = !inIdle && (toCnt == TO_LAST) && !mem.mem_ready;
    assign doneI  = (state == BUSY_I) && (mem.mem_ready || toHit);
    assign doneD  = (state == BUSY_D) && (mem.mem_ready || toHit);
    assign decide = inIdle || doneI || doneD;

    // The port being acked this edge drops out of the decision it shares the edge with.
    assign candI = if_req && !doneI;
    assign candD = d_req && !doneD;
    assign pickD = candD && ((runCnt < RUN_MAX) || !candI);
    assign pickI = candI && !pickD;

    // A misaligned data access is answered straight from IDLE without touching memory.
    // If it would be chosen on a fetch-completion edge, the FSM returns to IDLE and
    // answers it one edge later, so its err never shares a cycle with if_ack.
    assign grantD = decide && pickD && !dMisalign;
    assign grantI = decide && pickI;
    assign misD   = inIdle && pickD && dMisalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            toCnt         <= '0;
            runCnt        <= '0;
            if_ack        <= 1'b0;
            if_rdata      <= '0;
            d_ack         <= 1'b0;
            d_rdata       <= '0;
            err           <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= 4'b0000;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;

            if (doneI) begin
                if_ack   <= 1'b1;
                if_rdata <= mem.mem_ready ? mem.mem_rdata : '0;
                err      <= !mem.mem_ready;
            end

            if (doneD) begin
                d_ack   <= 1'b1;
                d_rdata <= mem.mem_ready ? mem.mem_rdata : '0;
                err     <= !mem.mem_ready;
            end

            if (misD) begin
                d_ack   <= 1'b1;
                d_rdata <= '0;
                err     <= 1'b1;
            end

            if (doneI || doneD) mem.mem_req <= 1'b0;

            if (grantD) begin
                state         <= BUSY_D;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= d_we;
                mem.mem_addr  <= {d_addr[AW-1:2], 2'b00};
                mem.mem_wdata <= dWdata;
                mem.mem_be    <= dBe;
            end else if (grantI) begin
                state         <= BUSY_I;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= {if_addr[AW-1:2], 2'b00};
                mem.mem_wdata <= '0;
                mem.mem_be    <= 4'b1111;
            end else if (doneI || doneD) begin
                state <= IDLE;
            end

            if (grantD || grantI) begin
                toCnt <= '0;
            end else if (!inIdle) begin
                toCnt <= toCnt + TW'(1);
            end else begin
                toCnt <= '0;
            end

            // Run length of data grants that starved a waiting fetch.
            if (!if_req || grantI) begin
                runCnt <= '0;
            end else if ((grantD || misD) && (runCnt < RUN_MAX)) begin
                runCnt <= runCnt + RW'(1);
            end
        end
    end

    assign core_stall = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign dbgState   = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks and memory requests go into
// queues when stimulus is issued; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int ACK_W = 51;  // {cycle[15:0], port[1:0], err, rdata[31:0]}
    localparam int MEM_W = 85;  // {cycle[15:0], we, be[3:0], addr[31:0], wdata[31:0]}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [2:0]    d_funct3 = 3'b000;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          core_stall;
    logic [1:0]    dbgState;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) memBus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(64), .MAX_DATA_RUN(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .err        (err),
        .mem        (memBus),
        .core_stall (core_stall),
        .dbgState   (dbgState)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [ACK_W-1:0] exp_q[$];
    logic [MEM_W-1:0] expMem_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- memory responder ----------------
    int memLat = 0;   // cycles of mem_req before mem_ready; negative = never answer
    int waitCnt = 0;

    initial begin
        memBus.mem_ready = 1'b0;
        memBus.mem_rdata = 32'hFFFF_FFFF;
    end

    always @(posedge clk) begin
        #1;
        memBus.mem_ready = 1'b0;
        memBus.mem_rdata = 32'hFFFF_FFFF;
        if (!memBus.mem_req || if_ack || d_ack) waitCnt = 0;
        if (memBus.mem_req && memLat >= 0) begin
            if (waitCnt == memLat) begin
                memBus.mem_ready = 1'b1;
                memBus.mem_rdata = memModel(memBus.mem_addr);
            end
            waitCnt++;
        end
    end

    // ---------------- monitor ----------------
    task automatic popAck(input logic [ACK_W-1:0] act);
        logic [ACK_W-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL ack: got {cyc,port,err,rdata}=%h with none expected", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL ack: got {cyc,port,err,rdata}=%h expected %h", act, e);
            end
        end
    endtask

    task automatic popMem(input logic [MEM_W-1:0] act);
        logic [MEM_W-1:0] e;
        vectors++;
        if (expMem_q.size() == 0) begin
            miscompares++;
            $display("FAIL memreq: got {cyc,we,be,addr,wdata}=%h with none expected", act);
        end else begin
            e = expMem_q.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL memreq: got {cyc,we,be,addr,wdata}=%h expected %h", act, e);
            end
        end
    endtask

    logic prevReq = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (if_ack) popAck({cyc[15:0], 2'd1, err, if_rdata});
            if (d_ack)  popAck({cyc[15:0], 2'd2, err, d_rdata});
            if (err && !if_ack && !d_ack) check("errWithoutAck", {127'd0, err}, 128'd0);
            if (memBus.mem_req && (!prevReq || if_ack || d_ack))
                popMem({cyc[15:0], memBus.mem_we, memBus.mem_be, memBus.mem_addr,
                        memBus.mem_we ? memBus.mem_wdata : 32'h0});
        end
        prevReq = memBus.mem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pushAck(input int c, input logic [1:0] port, input logic e, input logic [31:0] rd);
        exp_q.push_back({16'(c), port, e, rd});
    endtask

    task automatic pushMem(input int c, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        expMem_q.push_back({16'(c), we, be, a, wd});
    endtask

    task automatic setData(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        d_we     = we;
        d_funct3 = f3;
        d_addr   = a;
        d_wdata  = wd;
        d_req    = 1'b1;
    endtask

    task automatic runUntilIdle(input int budget);
        int n = 0;
        while ((if_req || d_req) && n < budget) begin
            tick();
            n++;
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
        end
        vectors++;
        if (if_req || d_req) begin
            miscompares++;
            $display("FAIL idleWait: got requests still pending after %0d cycles, required none", budget);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    // ---------------- directed stimulus ----------------
    int t;

    initial begin
        repeat (3) tick();
        check("rstMemReq",   {127'd0, memBus.mem_req}, 128'd0);
        check("rstIfAck",    {127'd0, if_ack}, 128'd0);
        check("rstDAck",     {127'd0, d_ack}, 128'd0);
        check("rstErr",      {127'd0, err}, 128'd0);
        check("rstState",    {126'd0, dbgState}, 128'd0);
        check("rstMemBe",    {124'd0, memBus.mem_be}, 128'd0);
        check("rstMemAddr",  {96'd0, memBus.mem_addr}, 128'd0);
        check("rstStall",    {127'd0, core_stall}, 128'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Fetch alone, memory answers in the first busy cycle.
        memLat = 0;
        t = cyc;
        if_addr = 32'h100;
        if_req  = 1'b1;
        pushMem(t + 1, 1'b0, 4'hF, 32'h100, 32'h0);
        pushAck(t + 2, 2'd1, 1'b0, memModel(32'h100));
        #1;
        check("stallOnFetch", {127'd0, core_stall}, 128'd1);
        runUntilIdle(20);
        repeat (2) tick();

        // Fetch and store byte together: data first, fetch granted on the data ack edge.
        t = cyc;
        if_addr = 32'h104;
        if_req  = 1'b1;
        setData(1'b1, 3'b000, 32'h203, 32'h123456AB);
        pushMem(t + 1, 1'b1, 4'b1000, 32'h200, 32'hABABABAB);
        pushAck(t + 2, 2'd2, 1'b0, memModel(32'h200));
        pushMem(t + 2, 1'b0, 4'hF, 32'h104, 32'h0);
        pushAck(t + 3, 2'd1, 1'b0, memModel(32'h104));
        runUntilIdle(20);
        repeat (2) tick();

        // Back-to-back data requests with a fetch waiting: four data grants, then the fetch.
        t = cyc;
        if_addr = 32'h108;
        if_req  = 1'b1;
        setData(1'b1, 3'b010, 32'h102, 32'h0);
        for (int k = 1; k <= 4; k++) pushAck(t + k, 2'd2, 1'b1, 32'h0);
        pushMem(t + 5, 1'b0, 4'hF, 32'h108, 32'h0);
        pushAck(t + 6, 2'd1, 1'b0, memModel(32'h108));
        for (int k = 7; k <= 10; k++) pushAck(t + k, 2'd2, 1'b1, 32'h0);
        pushMem(t + 11, 1'b0, 4'hF, 32'h10C, 32'h0);
        pushAck(t + 12, 2'd1, 1'b0, memModel(32'h10C));
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 6) if_addr = 32'h10C;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) tick();

        // Load that the memory never answers: timeout 64 cycles after the grant.
        memLat = -1;
        t = cyc;
        setData(1'b0, 3'b010, 32'h300, 32'h0);
        pushMem(t + 1, 1'b0, 4'hF, 32'h300, 32'h0);
        pushAck(t + 65, 2'd2, 1'b1, 32'h0);
        runUntilIdle(100);
        check("timeoutReqLow", {127'd0, memBus.mem_req}, 128'd0);
        repeat (2) tick();

        // mem_ready on the last allowed cycle beats the timeout.
        memLat = 63;
        t = cyc;
        if_addr = 32'h400;
        if_req  = 1'b1;
        pushMem(t + 1, 1'b0, 4'hF, 32'h400, 32'h0);
        pushAck(t + 65, 2'd1, 1'b0, memModel(32'h400));
        runUntilIdle(100);
        repeat (2) tick();

        // Misaligned word store: no memory access, error ack next cycle.
        memLat = 0;
        t = cyc;
        setData(1'b1, 3'b010, 32'h102, 32'h55667788);
        pushAck(t + 1, 2'd2, 1'b1, 32'h0);
        runUntilIdle(10);
        check("misalignReqLow", {127'd0, memBus.mem_req}, 128'd0);
        tick();

        // Illegal size and odd halfword address are both rejected.
        t = cyc;
        setData(1'b0, 3'b011, 32'h100, 32'h0);
        pushAck(t + 1, 2'd2, 1'b1, 32'h0);
        runUntilIdle(10);
        tick();
        t = cyc;
        setData(1'b1, 3'b001, 32'h101, 32'h0);
        pushAck(t + 1, 2'd2, 1'b1, 32'h0);
        runUntilIdle(10);
        tick();

        // Halfword store at 0x102, memory latency 2.
        memLat = 2;
        t = cyc;
        setData(1'b1, 3'b001, 32'h102, 32'h1234CAFE);
        pushMem(t + 1, 1'b1, 4'b1100, 32'h100, 32'hCAFECAFE);
        pushAck(t + 4, 2'd2, 1'b0, memModel(32'h100));
        runUntilIdle(20);
        tick();

        // Byte store at 0x201, latency 1; byte load keeps all enables.
        memLat = 1;
        t = cyc;
        setData(1'b1, 3'b000, 32'h201, 32'h0000005A);
        pushMem(t + 1, 1'b1, 4'b0010, 32'h200, 32'h5A5A5A5A);
        pushAck(t + 3, 2'd2, 1'b0, memModel(32'h200));
        runUntilIdle(20);
        tick();
        memLat = 0;
        t = cyc;
        setData(1'b0, 3'b100, 32'h201, 32'h0);
        pushMem(t + 1, 1'b0, 4'hF, 32'h200, 32'h0);
        pushAck(t + 2, 2'd2, 1'b0, memModel(32'h200));
        runUntilIdle(20);
        tick();

        // Reset while a store is outstanding: request dropped, no ack.
        memLat = -1;
        t = cyc;
        setData(1'b1, 3'b010, 32'h500, 32'h11223344);
        pushMem(t + 1, 1'b1, 4'hF, 32'h500, 32'h11223344);
        tick();
        tick();
        check("busyDState", {126'd0, dbgState}, 128'd2);
        check("busyStall", {127'd0, core_stall}, 128'd1);
        rst_n = 1'b0;
        tick();
        check("rstMidReq", {127'd0, memBus.mem_req}, 128'd0);
        check("rstMidAck", {127'd0, d_ack}, 128'd0);
        check("rstMidState", {126'd0, dbgState}, 128'd0);
        check("rstMidStall", {127'd0, core_stall}, 128'd1);
        d_req = 1'b0;
        #1;
        check("rstMidStallDrop", {127'd0, core_stall}, 128'd0);
        tick();
        rst_n = 1'b1;
        memLat = 0;
        repeat (3) tick();

        check("ackQueueEmpty", 128'(exp_q.size()), 128'd0);
        check("memQueueEmpty", 128'(expMem_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
